row_packer_640x8: RTL and testbench

//  Write-side front end of the 480x5120 row frame buffer. Takes an 8-bit pixel

---
 rtl/row_packer_640x8.sv | 140 ++++++++++++++
 tb/tb_row_packer_640x8.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_packer_640x8.sv
// Packs a PIX_W-bit valid/ready pixel stream into COLS-pixel row words and
// issues one write per row into the row frame buffer, rows 0..ROWS-1 per frame.
module row_packer_640x8 #(
    parameter int PIX_W  = 8,
    parameter int COLS   = 640,
    parameter int ROWS   = 480,
    parameter int ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pix_valid,
    input  logic                    pix_sof,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [PIX_W*COLS-1:0]   mem_din,
    output logic                    row_done,
    output logic                    frame_done,
    output logic                    sof_err
);

    localparam int W     = PIX_W * COLS;
    localparam int COL_W = $clog2(COLS + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_FULL = COL_W'(COLS);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [W-1:0]        mem_din_q, mem_din_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic                frame_done_q, frame_done_d;
    logic                sof_err_q, sof_err_d;

    logic                xfer;
    logic [W-1:0]        shifted;

    // Ready is a pure state decode, forced low while reset is held.
    assign pix_ready = ~rst & ((state_q == IDLE) | (state_q == FILL));
    assign xfer      = pix_valid & pix_ready;
    assign shifted   = {pix_data, mem_din_q[W-1:PIX_W]};

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        mem_din_d    = mem_din_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        sof_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && pix_sof) begin
                    mem_din_d = shifted;
                    col_d     = COL_ONE;
                    row_d     = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    mem_din_d = shifted;
                    if (pix_sof) begin
                        // Restart the frame: the partial row is abandoned unwritten.
                        sof_err_d = 1'b1;
                        col_d     = COL_ONE;
                        row_d     = '0;
                    end else if (col_q == COL_LAST) begin
                        col_d      = COL_FULL;
                        mem_we_d   = 1'b1;
                        mem_addr_d = row_q;
                        state_d    = WRITE;
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end
            end
            WRITE: begin
                if (row_q == ROW_LAST) begin
                    frame_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    row_d   = row_q + ROW_ONE;
                    col_d   = '0;
                    state_d = FILL;
                end
            end
            DONE: begin
                row_d   = '0;
                col_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            mem_din_q    <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            mem_din_q    <= mem_din_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            frame_done_q <= frame_done_d;
            sof_err_q    <= sof_err_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign row_done   = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign frame_done = frame_done_q;
    assign sof_err    = sof_err_q;

endmodule

// File: tb/tb_row_packer_640x8.sv
// Directed bench: a full-size packer for row/SOF/reset cases and a small
// instance (8x5) that runs a complete frame with random valid gaps.
module tb_row_packer_640x8;

    localparam int PW     = 8;
    localparam int COLS   = 640;
    localparam int ROWS   = 480;
    localparam int AW     = 9;
    localparam int W      = PW * COLS;
    localparam int S_COLS = 8;
    localparam int S_ROWS = 5;
    localparam int S_AW   = 3;
    localparam int S_W    = PW * S_COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          pv = 1'b0, psof = 1'b0;
    logic [PW-1:0] pd = '0;
    logic          pr, we, rd, fd, se;
    logic [AW-1:0] addr;
    logic [W-1:0]  din;

    logic            s_pv = 1'b0, s_psof = 1'b0;
    logic [PW-1:0]   s_pd = '0;
    logic            s_pr, s_we, s_rd, s_fd, s_se;
    logic [S_AW-1:0] s_addr;
    logic [S_W-1:0]  s_din;

    row_packer_640x8 #(.PIX_W(PW), .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .pix_valid(pv), .pix_sof(psof), .pix_data(pd),
        .pix_ready(pr), .mem_we(we), .mem_addr(addr), .mem_din(din),
        .row_done(rd), .frame_done(fd), .sof_err(se)
    );

    row_packer_640x8 #(.PIX_W(PW), .COLS(S_COLS), .ROWS(S_ROWS), .ADDR_W(S_AW)) dut_s (
        .clk(clk), .rst(rst), .pix_valid(s_pv), .pix_sof(s_psof), .pix_data(s_pd),
        .pix_ready(s_pr), .mem_we(s_we), .mem_addr(s_addr), .mem_din(s_din),
        .row_done(s_rd), .frame_done(s_fd), .sof_err(s_se)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;
    int se_cnt   = 0;
    int s_wr_cnt = 0;
    int s_fd_cnt = 0;
    logic s_last_we_top = 1'b0;
    logic [S_W-1:0] s_exp [S_ROWS];

    task automatic finish_sim();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_row(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int k;
        k = 0;
        for (int c = COLS - 1; c >= 0; c--)
            if (obs[c*PW +: PW] !== exp[c*PW +: PW]) k = c;
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: pixel %0d observed %02h expected %02h",
                    tag, k, obs[k*PW +: PW], exp[k*PW +: PW]);
    endtask

    function automatic logic [PW-1:0] pix(input int pat, input int r, input int c);
        return PW'((c * pat + r * 7) & 255);
    endfunction

    function automatic logic [W-1:0] row_vec(input int pat, input int r);
        logic [W-1:0] v;
        for (int c = 0; c < COLS; c++) v[c*PW +: PW] = pix(pat, r, c);
        return v;
    endfunction

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send(input logic sof, input logic [PW-1:0] d);
        int g;
        g = 0;
        pv = 1'b1; psof = sof; pd = d;
        while (!pr && g < 8) begin @(negedge clk); g++; end
        if (!pr) begin
            n_checks++;
            $error("FAIL send_timeout: pix_ready observed 0 for %0d cycles, expected 1", g);
            finish_sim();
        end
        @(negedge clk);
        pv = 1'b0; psof = 1'b0;
    endtask

    task automatic s_send(input logic sof, input logic [PW-1:0] d);
        int g;
        int gap;
        g = 0;
        gap = $urandom_range(0, 2);
        s_pv = 1'b0;
        repeat (gap) @(negedge clk);
        s_pv = 1'b1; s_psof = sof; s_pd = d;
        while (!s_pr && g < 8) begin @(negedge clk); g++; end
        if (!s_pr) begin
            n_checks++;
            $error("FAIL s_send_timeout: pix_ready observed 0 for %0d cycles, expected 1", g);
            finish_sim();
        end
        @(negedge clk);
        s_pv = 1'b0; s_psof = 1'b0;
    endtask

    task automatic send_row(input int pat, input int r, input int ncols, input bit sof_first);
        for (int c = 0; c < ncols; c++) send(sof_first && c == 0, pix(pat, r, c));
    endtask

    task automatic check_write(input string tag, input int a, input int pat, input int r);
        chk({tag, "_we"},    64'(we),   64'd1);
        chk({tag, "_rd"},    64'(rd),   64'd1);
        chk({tag, "_addr"},  64'(addr), 64'(a));
        chk({tag, "_ready"}, 64'(pr),   64'd0);
        chk_row({tag, "_din"}, din, row_vec(pat, r));
        $display("row write %s addr=%0d checked", tag, addr);
    endtask

    // Scoreboard/monitor: counts pulses on the full-size instance and checks every
    // write of the small instance against the rows it was fed.
    always @(negedge clk) begin
        if (!rst) begin
            if (we) we_cnt++;
            if (se) se_cnt++;
            if (s_we) begin
                chk("s_addr", 64'(s_addr), 64'(s_wr_cnt));
                chk("s_row", 64'(s_din), (s_wr_cnt < S_ROWS) ? 64'(s_exp[s_wr_cnt]) : 64'hDEAD_BEEF);
                $display("small row write addr=%0d data=%016h", s_addr, s_din);
                s_wr_cnt++;
            end
            if (s_fd) begin
                s_fd_cnt++;
                chk("s_fd_after_last_write", 64'(s_last_we_top), 64'd1);
            end
            if (s_we || s_fd) chk("s_we_fd_exclusive", 64'(s_we & s_fd), 64'd0);
            s_last_we_top = s_we && (s_addr == S_AW'(S_ROWS - 1));
        end
    end

    initial begin
        #2ms;
        n_checks++;
        $error("FAIL watchdog: simulation time observed 2ms, expected completion earlier");
        finish_sim();
    end

    initial begin
        int base;
        logic [PW-1:0] d;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(pr), 64'd0);
        chk("rst_we",    64'(we), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Idle after reset
        chk("idle_ready", 64'(pr),   64'd1);
        chk("idle_we",    64'(we),   64'd0);
        chk("idle_addr",  64'(addr), 64'd0);
        chk("idle_fd",    64'(fd),   64'd0);
        chk("idle_se",    64'(se),   64'd0);
        chk_row("idle_din", din, '0);

        // First row, pixel value = column
        send_row(1, 0, COLS, 1'b1);
        check_write("t2", 0, 1, 0);
        chk("t2_pix0",   64'(din[7:0]),       64'h00);
        chk("t2_pix639", 64'(din[5119:5112]), 64'h7F);
        chk("t2_fd",     64'(fd),             64'd0);
        @(negedge clk);
        chk("t2_we_low",    64'(we),   64'd0);
        chk("t2_addr_hold", 64'(addr), 64'd0);
        chk("t2_ready",     64'(pr),   64'd1);

        // Rows 1..2, then SOF mid-row 3
        send_row(2, 1, COLS, 1'b0);
        check_write("t5_r1", 1, 2, 1);
        send_row(2, 2, COLS, 1'b0);
        check_write("t5_r2", 2, 2, 2);
        send_row(2, 3, 200, 1'b0);
        #1;
        base = we_cnt;
        chk("t5_writes_before", 64'(we_cnt), 64'd3);
        send(1'b1, pix(3, 0, 0));
        chk("t5_sof_err", 64'(se), 64'd1);
        chk("t5_no_we",   64'(we), 64'd0);
        send(1'b0, pix(3, 0, 1));
        chk("t5_sof_err_pulse", 64'(se), 64'd0);
        for (int c = 2; c < COLS; c++) send(1'b0, pix(3, 0, c));
        check_write("t5_new", 0, 3, 0);
        #1;
        chk("t5_one_write", 64'(we_cnt), 64'(base + 1));
        chk("t5_se_cnt",    64'(se_cnt), 64'd1);

        // Non-SOF pixels in IDLE are swallowed
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        base = we_cnt;
        for (int i = 0; i < 100; i++) begin
            d = PW'(i + 1);
            send(1'b0, d);
        end
        #1;
        chk("t4_no_we",    64'(we_cnt), 64'(base));
        chk("t4_no_se",    64'(se_cnt), 64'd1);
        chk("t4_ready",    64'(pr),     64'd1);
        chk_row("t4_din_clear", din, '0);

        // Async reset at row 10, col 300
        for (int r = 0; r < 10; r++) begin
            send_row(4, r, COLS, r == 0);
            check_write($sformatf("t6_r%0d", r), r, 4, r);
        end
        send_row(4, 10, 300, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_we",    64'(we),   64'd0);
        chk("t6_async_rd",    64'(rd),   64'd0);
        chk("t6_async_addr",  64'(addr), 64'd0);
        chk("t6_async_ready", 64'(pr),   64'd0);
        chk_row("t6_async_din", din, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_row(5, 0, COLS, 1'b1);
        check_write("t6_new_r0", 0, 5, 0);
        send_row(5, 1, COLS, 1'b0);
        check_write("t6_new_r1", 1, 5, 1);

        // Complete small frame with random valid gaps
        for (int r = 0; r < S_ROWS; r++) begin
            for (int c = 0; c < S_COLS; c++) begin
                d = PW'($urandom_range(0, 255));
                s_exp[r][c*PW +: PW] = d;
                s_send(r == 0 && c == 0, d);
            end
        end
        chk("t3_last_we",   64'(s_we),   64'd1);
        chk("t3_last_addr", 64'(s_addr), 64'(S_ROWS - 1));
        @(negedge clk);
        chk("t3_fd",       64'(s_fd), 64'd1);
        chk("t3_done_rdy", 64'(s_pr), 64'd0);
        chk("t3_done_we",  64'(s_we), 64'd0);
        @(negedge clk);
        chk("t3_idle_rdy", 64'(s_pr), 64'd1);
        chk("t3_fd_pulse", 64'(s_fd), 64'd0);
        #1;
        chk("t3_writes",   64'(s_wr_cnt), 64'(S_ROWS));
        chk("t3_fd_count", 64'(s_fd_cnt), 64'd1);

        finish_sim();
    end

endmodule
